// File: rtl/axi_resp_pkg.sv
// rtl/axi_resp_pkg.sv - shared encodings and widths for the AXI DDR stand-in responder
package axi_resp_pkg;

  localparam int ID_WIDTH  = 4;
  localparam int LEN_WIDTH = 4;
  localparam int DLY_WIDTH = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ADDR  = 2'd1,
    R_FETCH = 2'd2,
    R_DATA  = 2'd3
  } rstate_e;

  // Anything but INCR is flagged; the burst itself is still walked as INCR.
  function automatic logic burst_unsupported(input logic [1:0] burst);
    return burst != BURST_INCR;
  endfunction

endpackage

// File: rtl/axi_ddr_responder_if.sv
// rtl/axi_ddr_responder_if.sv - AXI write/read channel bundle in the DDR controller signal style
interface axi_ddr_responder_if #(
  parameter int MEM_DQ_WIDTH    = 32,
  parameter int CTRL_ADDR_WIDTH = 28
);
  import axi_resp_pkg::*;

  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr;
  logic [ID_WIDTH-1:0]        axi_awid;
  logic [LEN_WIDTH-1:0]       axi_awlen;
  logic [2:0]                 axi_awsize;
  logic [1:0]                 axi_awburst;
  logic                       axi_awvalid;
  logic                       axi_awready;

  logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata;
  logic [MEM_DQ_WIDTH-1:0]    axi_wstrb;
  logic                       axi_wvalid;
  logic                       axi_wready;
  logic                       axi_wlast;

  logic [ID_WIDTH-1:0]        axi_bid;
  logic                       axi_bvalid;
  logic                       axi_bready;

  logic [CTRL_ADDR_WIDTH-1:0] axi_araddr;
  logic [ID_WIDTH-1:0]        axi_arid;
  logic [LEN_WIDTH-1:0]       axi_arlen;
  logic [2:0]                 axi_arsize;
  logic [1:0]                 axi_arburst;
  logic                       axi_arvalid;
  logic                       axi_arready;

  logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata;
  logic                       axi_rvalid;
  logic                       axi_rlast;
  logic [ID_WIDTH-1:0]        axi_rid;
  logic                       axi_rready;

  modport master (
    output axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready, axi_wlast,
    input  axi_bid, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rvalid, axi_rlast, axi_rid,
    output axi_rready
  );

  modport slave (
    input  axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready, axi_wlast,
    output axi_bid, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rvalid, axi_rlast, axi_rid,
    input  axi_rready
  );

endinterface

// File: rtl/axi_resp_ram.sv
// rtl/axi_resp_ram.sv - beat-wide dual-port RAM: byte-enabled write port A, registered read-first port B
module axi_resp_ram #(
  parameter int NB = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [NB*8-1:0] a_wdata,
  input  logic [NB-1:0]   a_strb,
  input  logic            b_en,
  input  logic [AW-1:0]   b_addr,
  output logic [NB*8-1:0] b_rdata
);

  logic [NB*8-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_we) begin
      for (int i = 0; i < NB; i++) begin
        if (a_strb[i]) begin
          mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Only the output register is reset; it holds whenever b_en is low so a stalled beat stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_rdata <= '0;
    end else if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/axi_ddr_responder.sv
// rtl/axi_ddr_responder.sv - AXI slave standing in for the DDR controller, backed by on-chip RAM
module axi_ddr_responder
  import axi_resp_pkg::*;
#(
  parameter int MEM_DQ_WIDTH    = 32,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int ADDR_LSB        = 3,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int AW_ACCEPT_DELAY = 0
) (
  input  logic               clk,
  input  logic               rst,
  axi_ddr_responder_if.slave axi,
  output logic               burst_err
);

  localparam logic [DLY_WIDTH-1:0]      ACCEPT_DLY = DLY_WIDTH'(AW_ACCEPT_DELAY);
  localparam logic [MEM_ADDR_WIDTH-1:0] IDX_ONE    = MEM_ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]      CNT_ONE    = LEN_WIDTH'(1);

  wstate_e                   w_state, w_next;
  logic [DLY_WIDTH-1:0]      w_dly;
  logic [MEM_ADDR_WIDTH-1:0] w_idx;
  logic [LEN_WIDTH-1:0]      w_len, w_cnt;
  logic [ID_WIDTH-1:0]       w_id;
  logic                      w_beat;

  rstate_e                   r_state, r_next;
  logic [DLY_WIDTH-1:0]      r_dly;
  logic [MEM_ADDR_WIDTH-1:0] r_idx;
  logic [LEN_WIDTH-1:0]      r_len, r_cnt;
  logic [ID_WIDTH-1:0]       r_id;
  logic                      r_fetch;

  logic [MEM_DQ_WIDTH*8-1:0] ram_rdata;

  logic [CTRL_ADDR_WIDTH-1:0] unused_addr;
  logic                       unused_bits;
  assign unused_addr = axi.axi_awaddr ^ axi.axi_araddr;
  assign unused_bits = ^{unused_addr, axi.axi_awsize, axi.axi_arsize};

  // Write channel
  always_comb begin
    w_next          = w_state;
    axi.axi_awready = 1'b0;
    axi.axi_wready  = 1'b0;
    axi.axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (axi.axi_awvalid) w_next = W_ADDR;
      end
      W_ADDR: begin
        if (w_dly == '0) begin
          axi.axi_awready = 1'b1;
          w_next          = W_DATA;
        end
      end
      W_DATA: begin
        axi.axi_wready = 1'b1;
        if (axi.axi_wvalid && (w_cnt == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        axi.axi_bvalid = 1'b1;
        if (axi.axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign w_beat        = axi.axi_wready && axi.axi_wvalid;
  assign axi.axi_wlast = axi.axi_wready && (w_cnt == w_len);
  assign axi.axi_bid   = w_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_dly   <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_id    <= '0;
    end else begin
      w_state <= w_next;
      case (w_state)
        W_IDLE: w_dly <= ACCEPT_DLY;
        W_ADDR: begin
          if (w_dly != '0) begin
            w_dly <= w_dly - DLY_WIDTH'(1);
          end else begin
            w_idx <= axi.axi_awaddr[ADDR_LSB +: MEM_ADDR_WIDTH];
            w_len <= axi.axi_awlen;
            w_id  <= axi.axi_awid;
            w_cnt <= '0;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_idx <= w_idx + IDX_ONE;
            w_cnt <= w_cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read channel: the next beat is fetched in the same cycle the current one is taken.
  always_comb begin
    r_next          = r_state;
    axi.axi_arready = 1'b0;
    axi.axi_rvalid  = 1'b0;
    r_fetch         = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (axi.axi_arvalid) r_next = R_ADDR;
      end
      R_ADDR: begin
        if (r_dly == '0) begin
          axi.axi_arready = 1'b1;
          r_next          = R_FETCH;
        end
      end
      R_FETCH: begin
        r_fetch = 1'b1;
        r_next  = R_DATA;
      end
      R_DATA: begin
        axi.axi_rvalid = 1'b1;
        if (axi.axi_rready) begin
          if (r_cnt == r_len) r_next = R_IDLE;
          else                r_fetch = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign axi.axi_rlast = axi.axi_rvalid && (r_cnt == r_len);
  assign axi.axi_rid   = r_id;
  assign axi.axi_rdata = ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_dly   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE) r_dly <= ACCEPT_DLY;
      if (r_state == R_ADDR) begin
        if (r_dly != '0) begin
          r_dly <= r_dly - DLY_WIDTH'(1);
        end else begin
          r_idx <= axi.axi_araddr[ADDR_LSB +: MEM_ADDR_WIDTH];
          r_len <= axi.axi_arlen;
          r_id  <= axi.axi_arid;
          r_cnt <= '0;
        end
      end
      if (r_fetch) r_idx <= r_idx + IDX_ONE;
      if (r_fetch && (r_state == R_DATA)) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_err <= 1'b0;
    end else if ((axi.axi_awready && burst_unsupported(axi.axi_awburst)) ||
                 (axi.axi_arready && burst_unsupported(axi.axi_arburst))) begin
      burst_err <= 1'b1;
    end
  end

  axi_resp_ram #(
    .NB (MEM_DQ_WIDTH),
    .AW (MEM_ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_we    (w_beat),
    .a_addr  (w_idx),
    .a_wdata (axi.axi_wdata),
    .a_strb  (axi.axi_wstrb),
    .b_en    (r_fetch),
    .b_addr  (r_idx),
    .b_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_ddr_responder.sv
// tb/tb_axi_ddr_responder.sv - scoreboard bench for axi_ddr_responder
module tb_axi_ddr_responder;
  import axi_resp_pkg::*;

  localparam int DLY = 4;

  typedef struct {
    logic [255:0] data;
    logic         last;
    logic [3:0]   id;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic burst_err;
  int   n_vec = 0;
  int   n_err = 0;

  logic [255:0] model [1024];
  logic         exp_w [$];
  logic [3:0]   exp_b [$];
  rexp_t        exp_r [$];

  always #5 clk = ~clk;

  axi_ddr_responder_if #(.MEM_DQ_WIDTH(32), .CTRL_ADDR_WIDTH(28)) axi ();

  axi_ddr_responder #(
    .MEM_DQ_WIDTH(32), .CTRL_ADDR_WIDTH(28), .ADDR_LSB(3),
    .MEM_ADDR_WIDTH(10), .AW_ACCEPT_DELAY(DLY)
  ) dut (
    .clk(clk), .rst(rst), .axi(axi), .burst_err(burst_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    rexp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (axi.axi_wvalid && axi.axi_wready) begin
          if (exp_w.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL w_extra: beat accepted with nothing expected");
          end else check("wlast", 256'(axi.axi_wlast), 256'(exp_w.pop_front()));
        end
        if (axi.axi_bvalid && axi.axi_bready) begin
          if (exp_b.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL b_extra: response with nothing expected");
          end else check("bid", 256'(axi.axi_bid), 256'(exp_b.pop_front()));
        end
        if (axi.axi_rvalid && axi.axi_rready) begin
          if (exp_r.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL r_extra: read beat with nothing expected");
          end else begin
            e = exp_r.pop_front();
            check("rdata", axi.axi_rdata, e.data);
            check("rlast", 256'(axi.axi_rlast), 256'(e.last));
            check("rid", 256'(axi.axi_rid), 256'(e.id));
          end
        end
      end
    end
  endtask

  task automatic do_write(input logic [27:0] addr, input int len, input logic [3:0] id,
                          input logic [31:0] strb, input logic [255:0] base, input int abort_at);
    int idx, c, k;
    logic [255:0] d;
    idx = int'(addr[12:3]);
    axi.axi_awaddr = addr; axi.axi_awlen = 4'(len); axi.axi_awid = id;
    axi.axi_awburst = BURST_INCR; axi.axi_awvalid = 1'b1;
    c = 0;
    while (!axi.axi_awready && c < 100) begin tick(); c++; end
    check("aw_latency", 256'(c), 256'(DLY + 1));
    tick();
    axi.axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      d = base ^ 256'(b);
      axi.axi_wdata = d; axi.axi_wstrb = strb; axi.axi_wvalid = 1'b1;
      if (b == abort_at) begin
        #1 rst = 1'b1;
        #1;
        return;
      end
      exp_w.push_back(b == len);
      c = 0;
      while (!axi.axi_wready && c < 100) begin tick(); c++; end
      tick();
      k = (idx + b) % 1024;
      for (int i = 0; i < 32; i++) if (strb[i]) model[k][i*8 +: 8] = d[i*8 +: 8];
    end
    axi.axi_wvalid = 1'b0;
    exp_b.push_back(id);
    axi.axi_bready = 1'b1;
    c = 0;
    while (!axi.axi_bvalid && c < 100) begin tick(); c++; end
    check("b_seen", 256'(axi.axi_bvalid), 256'(1));
    tick();
    axi.axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [27:0] addr, input int len, input logic [3:0] id,
                         input logic [3:0] rpat);
    int idx, c, got, lat;
    logic stalled, hs, ar_h, hl;
    logic [255:0] hd;
    rexp_t e;
    idx = int'(addr[12:3]);
    for (int b = 0; b <= len; b++) begin
      e.data = model[(idx + b) % 1024]; e.last = (b == len); e.id = id;
      exp_r.push_back(e);
    end
    axi.axi_araddr = addr; axi.axi_arlen = 4'(len); axi.axi_arid = id;
    axi.axi_arburst = BURST_INCR; axi.axi_arvalid = 1'b1;
    c = 0; got = 0; lat = -1; stalled = 1'b0; hd = '0; hl = 1'b0;
    while (got <= len && c < 300) begin
      if (axi.axi_rvalid && lat < 0) begin
        lat = c;
        check("r_first_latency", 256'(lat), 256'(DLY + 3));
      end
      if (stalled) begin
        check("r_hold_valid", 256'(axi.axi_rvalid), 256'(1));
        check("r_hold_data", axi.axi_rdata, hd);
        check("r_hold_last", 256'(axi.axi_rlast), 256'(hl));
      end
      axi.axi_rready = rpat[c % 4];
      ar_h    = axi.axi_arready;
      hs      = axi.axi_rvalid && axi.axi_rready;
      stalled = axi.axi_rvalid && !axi.axi_rready;
      hd      = axi.axi_rdata;
      hl      = axi.axi_rlast;
      tick();
      if (ar_h) axi.axi_arvalid = 1'b0;
      if (hs) got++;
      c++;
    end
    axi.axi_rready = 1'b0;
    check("r_beats", 256'(got), 256'(len + 1));
  endtask

  function automatic logic [15:0] ctrl_outs();
    return {axi.axi_awready, axi.axi_wready, axi.axi_wlast, axi.axi_bid, axi.axi_bvalid,
            axi.axi_arready, axi.axi_rvalid, axi.axi_rlast, axi.axi_rid, burst_err};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int aw_lat;
    logic aw_h, ar_h, w_h;
    rexp_t e;
    axi.axi_awaddr = '0; axi.axi_awid = '0; axi.axi_awlen = '0; axi.axi_awsize = 3'd5;
    axi.axi_awburst = BURST_INCR; axi.axi_awvalid = 1'b0;
    axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wvalid = 1'b0; axi.axi_bready = 1'b0;
    axi.axi_araddr = '0; axi.axi_arid = '0; axi.axi_arlen = '0; axi.axi_arsize = 3'd5;
    axi.axi_arburst = BURST_INCR; axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b0;
    fork monitor(); join_none

    repeat (3) tick();
    check("reset_ctrl", 256'(ctrl_outs()), 256'(0));
    check("reset_rdata", axi.axi_rdata, 256'(0));
    rst = 1'b0;
    tick();

    // 16-beat write then read at beat 0
    do_write(28'h0, 15, 4'hA, 32'hFFFF_FFFF, 256'h0, -1);
    do_read(28'h0, 15, 4'h5, 4'b1111);
    // stalled read
    do_read(28'h0, 15, 4'h6, 4'b1001);

    // partial strobe over a prefilled beat
    do_write({15'd0, 10'd200, 3'd0}, 0, 4'h1, 32'hFFFF_FFFF, {256{1'b1}}, -1);
    do_write({15'd0, 10'd200, 3'd0}, 0, 4'h2, 32'h0000_00FF,
             256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_0123_4567_89AB_CDEF, -1);
    do_read({15'd0, 10'd200, 3'd0}, 0, 4'h3, 4'b1111);
    check("strobe_merge", model[200],
          256'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0123_4567_89AB_CDEF);

    // wrap across the top of RAM; upper and sub-beat address bits are ignored
    do_write({15'h4001, 10'd1022, 3'd5}, 3, 4'h7, 32'hFFFF_FFFF, 256'hC0DE_0000, -1);
    do_read({15'd0, 10'd1022, 3'd0}, 3, 4'h8, 4'b1111);
    do_read(28'h0, 1, 4'h9, 4'b1111);

    // reset during beat 5 of an 8-beat write
    do_write({15'd0, 10'd100, 3'd0}, 7, 4'h3, 32'hFFFF_FFFF, 256'hAB00, 5);
    check("midrst_ctrl", 256'(ctrl_outs()), 256'(0));
    check("midrst_rdata", axi.axi_rdata, 256'(0));
    axi.axi_wvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    do_write({15'd0, 10'd400, 3'd0}, 2, 4'hC, 32'hFFFF_FFFF, 256'h5A5A_0000, -1);
    do_read({15'd0, 10'd400, 3'd0}, 2, 4'hD, 4'b1111);
    do_read({15'd0, 10'd100, 3'd0}, 4, 4'hE, 4'b1111);

    // WRAP burst type plus concurrent same-index read and write
    do_write({15'd0, 10'd300, 3'd0}, 0, 4'h1, 32'hFFFF_FFFF, 256'hAAAA_0001, -1);
    check("burst_err_clear", 256'(burst_err), 256'(0));
    axi.axi_awaddr = {15'd0, 10'd300, 3'd0}; axi.axi_awlen = 4'd0; axi.axi_awid = 4'h9;
    axi.axi_awburst = BURST_WRAP; axi.axi_awvalid = 1'b1;
    axi.axi_araddr = {15'd0, 10'd300, 3'd0}; axi.axi_arlen = 4'd0; axi.axi_arid = 4'h2;
    axi.axi_arburst = BURST_INCR; axi.axi_arvalid = 1'b1;
    axi.axi_wdata = 256'hBBBB_0002; axi.axi_wstrb = 32'hFFFF_FFFF; axi.axi_wvalid = 1'b1;
    axi.axi_bready = 1'b1; axi.axi_rready = 1'b1;
    exp_w.push_back(1'b1);
    exp_b.push_back(4'h9);
    e.data = 256'hAAAA_0001; e.last = 1'b1; e.id = 4'h2;
    exp_r.push_back(e);
    aw_lat = -1;
    for (int c = 0; c < 40; c++) begin
      aw_h = axi.axi_awready;
      ar_h = axi.axi_arready;
      w_h  = axi.axi_wready && axi.axi_wvalid;
      if (aw_h && aw_lat < 0) aw_lat = c;
      tick();
      if (aw_h) axi.axi_awvalid = 1'b0;
      if (ar_h) axi.axi_arvalid = 1'b0;
      if (w_h)  axi.axi_wvalid = 1'b0;
    end
    axi.axi_bready = 1'b0; axi.axi_rready = 1'b0; axi.axi_awburst = BURST_INCR;
    model[300] = 256'hBBBB_0002;
    check("wrap_aw_latency", 256'(aw_lat), 256'(5));
    check("burst_err_set", 256'(burst_err), 256'(1));
    do_read({15'd0, 10'd300, 3'd0}, 0, 4'h4, 4'b1111);
    do_write({15'd0, 10'd500, 3'd0}, 1, 4'h6, 32'hFFFF_FFFF, 256'h77, -1);
    check("burst_err_sticky", 256'(burst_err), 256'(1));

    repeat (3) tick();
    check("w_queue_drained", 256'(exp_w.size()), 256'(0));
    check("b_queue_drained", 256'(exp_b.size()), 256'(0));
    check("r_queue_drained", 256'(exp_r.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
